// File: rtl/bus_rx_queue_if.sv
// Handshake bundle between the shared datapath bus, the receive queue and its consumer.
// Latency: none; this is wiring only.
// Backpressure: carried by out_ready; a full queue drops strobed words and raises overflow.
//
// Signals:
//   bus_in/bus_src/bus_strobe  capture side: bus word, driver tag, capture request
//   out_data/out_src/out_valid/out_ready  consumer side valid/ready handshake
//   count/full/empty/overflow/ovf_clr     occupancy status and sticky drop flag
interface bus_rx_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int SRC_W = 3
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] bus_in;
    logic [SRC_W-1:0] bus_src;
    logic             bus_strobe;
    logic [WIDTH-1:0] out_data;
    logic [SRC_W-1:0] out_src;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             ovf_clr;

    // Environment side: drives the bus and the consumer controls.
    modport master (
        output bus_in, bus_src, bus_strobe, out_ready, ovf_clr,
        input  out_data, out_src, out_valid, count, full, empty, overflow
    );

    // Queue side.
    modport slave (
        input  bus_in, bus_src, bus_strobe, out_ready, ovf_clr,
        output out_data, out_src, out_valid, count, full, empty, overflow
    );
endinterface

// File: rtl/bus_rx_queue.sv
// Captures {bus_src, bus_in} on every bus_strobe into a DEPTH-entry FIFO drained by valid/ready.
// Latency: a word strobed in cycle N is at the head with out_valid=1 in cycle N+1 (no bypass).
// Backpressure: when full and not popping, a strobed word is dropped and sticky overflow is set.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset; clears pointers, count, storage and overflow
//   bif    bus_rx_queue_if.slave: bus capture inputs, consumer handshake, status outputs
module bus_rx_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int SRC_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_rx_queue_if.slave bif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = SRC_W + WIDTH;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic full, empty, push, pop, drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // out_valid is ~empty, so out_ready while empty never pops.
    assign pop   = ~empty & bif.out_ready;
    // A pop in the same cycle frees the slot the strobed word needs.
    assign push  = bif.bus_strobe & (~full | pop);
    assign drop  = bif.bus_strobe & ~push;

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
    assign wr_ptr_d = wr_ptr_q + AW'(push);
    assign rd_ptr_d = rd_ptr_q + AW'(pop);
    assign count_d  = count_q + CW'(push) - CW'(pop);
    // A drop in the same cycle as ovf_clr keeps the flag set.
    assign overflow_d = drop | (overflow_q & ~bif.ovf_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {bif.bus_src, bif.bus_in};
            end
        end
    end

    logic [EW-1:0] head;
    assign head = empty ? '0 : mem_q[rd_ptr_q];

    assign bif.out_data  = head[WIDTH-1:0];
    assign bif.out_src   = head[EW-1:WIDTH];
    assign bif.out_valid = ~empty;
    assign bif.count     = count_q;
    assign bif.full      = full;
    assign bif.empty     = empty;
    assign bif.overflow  = overflow_q;
endmodule
